// File: rtl/fft_pkg.sv
// Shared constants and types for the 32-point radix-2 DIT FFT sequencer.
package fft_pkg;

  localparam int FFT_N         = 32;
  localparam int FFT_LOG2N     = 5;
  localparam int ADDR_W        = FFT_LOG2N;
  localparam int TW_W          = FFT_LOG2N - 1;
  localparam int BF_PER_CYCLE  = 2;
  localparam int CYC_PER_STAGE = FFT_N / (2 * BF_PER_CYCLE);
  localparam int NUM_STAGES    = FFT_LOG2N;
  localparam int STAGE_W       = 3;
  localparam int CYC_W         = 3;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

  // One issue slot: strobe plus the four operand addresses.
  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] a0;
    logic [ADDR_W-1:0] a1;
    logic [ADDR_W-1:0] a2;
    logic [ADDR_W-1:0] a3;
  } slot_t;

endpackage

// File: rtl/fft32_addr_gen.sv
// Butterfly address/twiddle generator: (stage, butterfly index) -> (top, bot, k).
module fft32_addr_gen
  import fft_pkg::*;
(
  input  logic [STAGE_W-1:0] stage,
  input  logic [TW_W-1:0]    b,
  output logic [ADDR_W-1:0]  top,
  output logic [ADDR_W-1:0]  bot,
  output logic [TW_W-1:0]    k
);

  logic [ADDR_W-1:0] b_x;
  logic [ADDR_W-1:0] h;
  logic [ADDR_W-1:0] pos;
  logic [ADDR_W-1:0] grp;

  // top inserts a zero at bit position 'stage' of b; bot sets that bit.
  always_comb begin
    b_x = {1'b0, b};
    h   = ADDR_W'(1) << stage;
    pos = b_x & (h - ADDR_W'(1));
    grp = b_x >> stage;
    top = (grp << (stage + STAGE_W'(1))) | pos;
    bot = top + h;
    k   = TW_W'(pos << (STAGE_W'(TW_W) - stage));
  end

endmodule

// File: rtl/fft32_stage_ctrl.sv
// Stage sequencer for an in-place 32-point radix-2 DIT FFT driving a dual-butterfly
// datapath: issues read addresses/twiddles and delays them into write-back addresses.
module fft32_stage_ctrl
  import fft_pkg::*;
#(
  parameter int LOG2N    = 5,
  parameter int PIPE_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [2:0]       stage,
  output logic             rd_en,
  output logic [LOG2N-1:0] rd_addr0,
  output logic [LOG2N-1:0] rd_addr1,
  output logic [LOG2N-1:0] rd_addr2,
  output logic [LOG2N-1:0] rd_addr3,
  output logic [LOG2N-2:0] tw_idx0,
  output logic [LOG2N-2:0] tw_idx1,
  output logic             wr_en,
  output logic [LOG2N-1:0] wr_addr0,
  output logic [LOG2N-1:0] wr_addr1,
  output logic [LOG2N-1:0] wr_addr2,
  output logic [LOG2N-1:0] wr_addr3
);

  localparam logic [CYC_W-1:0]   LAST_CYC   = CYC_W'(CYC_PER_STAGE - 1);
  localparam logic [2:0]         LAST_DCNT  = 3'(PIPE_LAT - 1);
  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);

  state_t               state_q, state_d;
  logic [STAGE_W-1:0]   stage_q, stage_d;
  logic [CYC_W-1:0]     cyc_q, cyc_d;
  logic [2:0]           dcnt_q, dcnt_d;

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      stage_q <= '0;
      cyc_q   <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      cyc_q   <= cyc_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // NOTE: every comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    cyc_d   = cyc_q;
    dcnt_d  = dcnt_q;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = ISSUE;
        stage_d = '0;
        cyc_d   = '0;
      end
      ISSUE: if (cyc_q == LAST_CYC) begin
        state_d = DRAIN;
        dcnt_d  = '0;
      end else begin
        cyc_d = cyc_q + CYC_W'(1);
      end
      DRAIN: if (dcnt_q == LAST_DCNT) begin
        if (stage_q == LAST_STAGE) begin
          state_d = FINISH;
        end else begin
          state_d = ISSUE;
          stage_d = stage_q + STAGE_W'(1);
          cyc_d   = '0;
        end
      end else begin
        dcnt_d = dcnt_q + 3'd1;
      end
      FINISH: begin
        state_d = IDLE;
        stage_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state_q != IDLE);
    done  = (state_q == FINISH);
    stage = stage_q;
  end

  // Addresses are generated from next-state so they register alongside rd_en.
  logic [ADDR_W-1:0] top_a, bot_a, top_b, bot_b;
  logic [TW_W-1:0]   k_a, k_b;

  fft32_addr_gen u_gen_a (
    .stage (stage_d),
    .b     ({cyc_d, 1'b0}),
    .top   (top_a),
    .bot   (bot_a),
    .k     (k_a)
  );

  fft32_addr_gen u_gen_b (
    .stage (stage_d),
    .b     ({cyc_d, 1'b1}),
    .top   (top_b),
    .bot   (bot_b),
    .k     (k_b)
  );

  slot_t            rd_q;
  logic [TW_W-1:0]  tw0_q, tw1_q;
  slot_t            pipe_q [PIPE_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      tw0_q <= '0;
      tw1_q <= '0;
    end else if (state_d == ISSUE) begin
      rd_q  <= '{valid: 1'b1, a0: top_a, a1: top_b, a2: bot_a, a3: bot_b};
      tw0_q <= k_a;
      tw1_q <= k_b;
    end else begin
      rd_q  <= '0;
      tw0_q <= '0;
      tw1_q <= '0;
    end
  end

  // NOTE: the delay line is reset so no stale write strobe survives a mid-pass reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PIPE_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= rd_q;
      for (int i = 1; i < PIPE_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  always_comb begin
    rd_en    = rd_q.valid;
    rd_addr0 = rd_q.a0;
    rd_addr1 = rd_q.a1;
    rd_addr2 = rd_q.a2;
    rd_addr3 = rd_q.a3;
    tw_idx0  = tw0_q;
    tw_idx1  = tw1_q;
    wr_en    = pipe_q[PIPE_LAT-1].valid;
    wr_addr0 = pipe_q[PIPE_LAT-1].a0;
    wr_addr1 = pipe_q[PIPE_LAT-1].a1;
    wr_addr2 = pipe_q[PIPE_LAT-1].a2;
    wr_addr3 = pipe_q[PIPE_LAT-1].a3;
  end

endmodule

// File: tb/tb_fft32_stage_ctrl.sv
// Directed bench for fft32_stage_ctrl: cycle-exact schedule, addresses, write-back
// coverage, start handling and reset behaviour at the default PIPE_LAT of 2.
module tb_fft32_stage_ctrl;

  localparam int PL       = 2;
  localparam int P        = 8 + PL;
  localparam int DONE_CYC = 1 + 5 * P;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       busy, done, rd_en, wr_en;
  logic [2:0] stage;
  logic [4:0] rd_addr0, rd_addr1, rd_addr2, rd_addr3;
  logic [4:0] wr_addr0, wr_addr1, wr_addr2, wr_addr3;
  logic [3:0] tw_idx0, tw_idx1;

  fft32_stage_ctrl #(.LOG2N(5), .PIPE_LAT(PL)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .stage    (stage),
    .rd_en    (rd_en),
    .rd_addr0 (rd_addr0),
    .rd_addr1 (rd_addr1),
    .rd_addr2 (rd_addr2),
    .rd_addr3 (rd_addr3),
    .tw_idx0  (tw_idx0),
    .tw_idx1  (tw_idx1),
    .wr_en    (wr_en),
    .wr_addr0 (wr_addr0),
    .wr_addr1 (wr_addr1),
    .wr_addr2 (wr_addr2),
    .wr_addr3 (wr_addr3)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int tops [5][16];
  int wr_cnt [5][32];

  typedef struct {
    bit en;
    int a0, a1, a2, a3, t0, t1;
  } rd_exp_t;

  // Expected issue slot for cycle m after start acceptance: the j-th butterfly of
  // stage s uses the j-th address (ascending) whose bit s is clear.
  function automatic rd_exp_t exp_rd(int m);
    rd_exp_t e;
    int s, c, h;
    e = '{default: 0};
    if (m >= 1 && m <= 5 * P && ((m - 1) % P) < 8) begin
      s = (m - 1) / P;
      c = (m - 1) % P;
      h = 1 << s;
      e.en = 1'b1;
      e.a0 = tops[s][2*c];
      e.a1 = tops[s][2*c+1];
      e.a2 = e.a0 + h;
      e.a3 = e.a1 + h;
      e.t0 = (e.a0 % h) * (16 / h);
      e.t1 = (e.a1 % h) * (16 / h);
    end
    return e;
  endfunction

  function automatic logic [54:0] all_outs();
    return {busy, done, stage, rd_en, rd_addr0, rd_addr1, rd_addr2, rd_addr3,
            tw_idx0, tw_idx1, wr_en, wr_addr0, wr_addr1, wr_addr2, wr_addr3};
  endfunction

  // Checks cycles 1..last_n of a pass whose start was accepted at the preceding edge.
  task automatic run_pass(input int last_n, input bit pulse_mid, input bit chain);
    rd_exp_t e, w;
    logic [19:0] hv_rd;
    logic [7:0]  hv_tw;
    bit          has_hv;
    int          ws;
    for (int s = 0; s < 5; s++)
      for (int a = 0; a < 32; a++) wr_cnt[s][a] = 0;
    for (int n = 1; n <= last_n; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (pulse_mid && (n == 10 || n == 30)) start = 1'b1;
      if (chain && n == DONE_CYC + 1) start = 1'b1;
      e = exp_rd(n);
      w = exp_rd(n - PL);

      checks++;
      if (busy !== (n <= DONE_CYC)) begin
        errors++;
        $display("FAIL busy cycle %0d: got %b expected %b", n, busy, n <= DONE_CYC);
      end
      checks++;
      if (done !== (n == DONE_CYC)) begin
        errors++;
        $display("FAIL done cycle %0d: got %b expected %b", n, done, n == DONE_CYC);
      end
      checks++;
      if (stage !== 3'((n > DONE_CYC) ? 0 : (((n - 1) / P > 4) ? 4 : (n - 1) / P))) begin
        errors++;
        $display("FAIL stage cycle %0d: got %0d", n, stage);
      end
      checks++;
      if (rd_en !== e.en || {rd_addr0, rd_addr1, rd_addr2, rd_addr3} !==
          {5'(e.a0), 5'(e.a1), 5'(e.a2), 5'(e.a3)} ||
          {tw_idx0, tw_idx1} !== {4'(e.t0), 4'(e.t1)}) begin
        errors++;
        $display("FAIL read cycle %0d: got en=%b %0d %0d %0d %0d tw %0d %0d expected en=%b %0d %0d %0d %0d tw %0d %0d",
                 n, rd_en, rd_addr0, rd_addr1, rd_addr2, rd_addr3, tw_idx0, tw_idx1,
                 e.en, e.a0, e.a1, e.a2, e.a3, e.t0, e.t1);
      end
      checks++;
      if (wr_en !== w.en || {wr_addr0, wr_addr1, wr_addr2, wr_addr3} !==
          {5'(w.a0), 5'(w.a1), 5'(w.a2), 5'(w.a3)}) begin
        errors++;
        $display("FAIL write cycle %0d: got en=%b %0d %0d %0d %0d expected en=%b %0d %0d %0d %0d",
                 n, wr_en, wr_addr0, wr_addr1, wr_addr2, wr_addr3, w.en, w.a0, w.a1, w.a2, w.a3);
      end

      has_hv = 1'b1;
      case (n)
        1:         begin hv_rd = {5'd0,  5'd2,  5'd1,  5'd3};  hv_tw = {4'd0,  4'd0};  end
        8:         begin hv_rd = {5'd28, 5'd30, 5'd29, 5'd31}; hv_tw = {4'd0,  4'd0};  end
        2 * P + 2: begin hv_rd = {5'd2,  5'd3,  5'd6,  5'd7};  hv_tw = {4'd8,  4'd12}; end
        4 * P + 1: begin hv_rd = {5'd0,  5'd1,  5'd16, 5'd17}; hv_tw = {4'd0,  4'd1};  end
        4 * P + 8: begin hv_rd = {5'd14, 5'd15, 5'd30, 5'd31}; hv_tw = {4'd14, 4'd15}; end
        default:   begin hv_rd = '0; hv_tw = '0; has_hv = 1'b0; end
      endcase
      if (has_hv) begin
        checks++;
        if ({rd_addr0, rd_addr1, rd_addr2, rd_addr3} !== hv_rd || {tw_idx0, tw_idx1} !== hv_tw) begin
          errors++;
          $display("FAIL vector cycle %0d: got %h tw %h expected %h tw %h",
                   n, {rd_addr0, rd_addr1, rd_addr2, rd_addr3}, {tw_idx0, tw_idx1}, hv_rd, hv_tw);
        end
      end

      if (wr_en === 1'b1) begin
        ws = (n - 1 - PL) / P;
        if (ws >= 0 && ws < 5) begin
          wr_cnt[ws][wr_addr0]++;
          wr_cnt[ws][wr_addr1]++;
          wr_cnt[ws][wr_addr2]++;
          wr_cnt[ws][wr_addr3]++;
        end
      end
    end
    if (last_n > DONE_CYC) begin
      for (int s = 0; s < 5; s++)
        for (int a = 0; a < 32; a++) begin
          checks++;
          if (wr_cnt[s][a] != 1) begin
            errors++;
            $display("FAIL coverage stage %0d addr %0d: got %0d writes expected 1", s, a, wr_cnt[s][a]);
          end
        end
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (all_outs() !== '0) begin
        errors++;
        $display("FAIL reset outputs: got %h expected 0", all_outs());
      end
    end
    rst = 1'b0;
    run_pass(DONE_CYC + 1, 1'b0, 1'b0);
  endtask

  task automatic test_start_ignored();
    @(negedge clk);
    start = 1'b1;
    run_pass(DONE_CYC + 1, 1'b1, 1'b1);
  endtask

  task automatic test_back_to_back();
    run_pass(DONE_CYC + 1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1;
    run_pass(24, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (wr_en !== 1'b1) begin
      errors++;
      $display("FAIL pending write cycle 25: got %b expected 1", wr_en);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (all_outs() !== '0) begin
      errors++;
      $display("FAIL mid reset outputs: got %h expected 0", all_outs());
    end
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (all_outs() !== '0) begin
        errors++;
        $display("FAIL held reset outputs: got %h expected 0", all_outs());
      end
    end
    rst   = 1'b0;
    start = 1'b1;
    run_pass(DONE_CYC + 1, 1'b0, 1'b0);
  endtask

  initial begin
    for (int s = 0; s < 5; s++) begin
      int j;
      j = 0;
      for (int a = 0; a < 32; a++)
        if (((a >> s) & 1) == 0) begin
          tops[s][j] = a;
          j++;
        end
    end
    test_reset();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
